// File: rtl/serial_transceiver_pkg.sv
// rtl/serial_transceiver_pkg.sv - shared constants, state type and helpers for serial_transceiver
//
// Purpose: data word width, transmit FSM state encoding and the ceil-div
// helper used to size the number of transmit steps.
// Ports: none (package).
package serial_transceiver_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/serial_transceiver.sv
// rtl/serial_transceiver.sv - 32-bit parallel-to-serial transmitter, WIDTH bits per step
//
// Purpose: captures din on sample, then on startTx shifts the held word out
// on dout one WIDTH-bit chunk per txEn step, with txBusy/txDone status.
// Optional build macro: SERIAL_TX_MSB_FIRST_EN reverses the chunk order
// (highest, zero-padded chunk first); timing is unchanged.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   din      in   [31:0] parallel data word
//   sample   in   load strobe, captures din (IDLE only)
//   startTx  in   start transmission of the held word (IDLE only)
//   txEn     in   step enable, one chunk advance per enabled edge
//   txDone   out  one-cycle pulse after the last chunk
//   txBusy   out  high while chunks are being driven
//   dout     out  [WIDTH-1:0] current chunk
module serial_transceiver
    import serial_transceiver_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              sample,
    input  logic              startTx,
    input  logic              txEn,
    output logic              txDone,
    output logic              txBusy,
    output logic [WIDTH-1:0]  dout
);

    localparam int CHUNKS = ceil_div(DATA_W, WIDTH);
    localparam int PAD_W  = CHUNKS * WIDTH;
    localparam int IDX_W  = $clog2(CHUNKS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // pos is the position in transmit order; it is mapped onto the physical
    // chunk of the zero-extended word, so the top chunk reads padding as 0.
    function automatic logic [WIDTH-1:0] chunk_at(input logic [DATA_W-1:0] word,
                                                  input logic [IDX_W-1:0]  pos);
        logic [IDX_W-1:0] phys;
        logic [PAD_W-1:0] shifted;
`ifdef SERIAL_TX_MSB_FIRST_EN
        phys = LAST_IDX - IDX_W'(1) - pos;
`else
        phys = pos;
`endif
        shifted = PAD_W'(word) >> (int'(phys) * WIDTH);
        return shifted[WIDTH-1:0];
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: FSM state, chunk index and holding register
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                // sample wins over startTx in the same cycle
                if (sample) begin
                    hold_d = din;
                end else if (startTx) begin
                    state_d = SEND;
                    idx_d   = IDX_W'(1);
                end
            end
            SEND: begin
                if (txEn) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else begin
                        state_d = DONE;
                        idx_d   = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output logic: registered dout/txBusy/txDone next values
    always_comb begin
        dout_d = dout_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                dout_d = '0;
                busy_d = 1'b0;
                // the first chunk goes out on the start edge, without txEn
                if (!sample && startTx) begin
                    dout_d = chunk_at(hold_q, '0);
                    busy_d = 1'b1;
                end
            end
            SEND: begin
                if (txEn) begin
                    if (idx_q < LAST_IDX) begin
                        dout_d = chunk_at(hold_q, idx_q);
                    end else begin
                        dout_d = '0;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                dout_d = '0;
                busy_d = 1'b0;
            end
            default: begin
                dout_d = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign dout   = dout_q;
    assign txBusy = busy_q;
    assign txDone = done_q;

endmodule

// File: tb/tb_serial_transceiver.sv
// tb/tb_serial_transceiver.sv - self-checking bench for serial_transceiver
module tb_serial_transceiver;

    localparam int W   = 5;
    localparam int NCH = (32 + W - 1) / W;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   din;
    logic          sample;
    logic          startTx;
    logic          txEn;
    logic          txDone;
    logic          txBusy;
    logic [W-1:0]  dout;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] last_seq[$];

    always #5 clk = ~clk;

    serial_transceiver #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .sample  (sample),
        .startTx (startTx),
        .txEn    (txEn),
        .txDone  (txDone),
        .txBusy  (txBusy),
        .dout    (dout)
    );

    // k-th chunk in transmit order, from plain shift/mask arithmetic
    function automatic logic [W-1:0] ref_chunk(input logic [31:0] w, input int k);
        int          phys;
        logic [63:0] x;
`ifdef SERIAL_TX_MSB_FIRST_EN
        phys = NCH - 1 - k;
`else
        phys = k;
`endif
        x = {32'd0, w} >> (phys * W);
        return x[W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; sample = 1'b0; startTx = 1'b0; txEn = 1'b0; din = '0;
        step();
        step();
        n_cmp++; if (dout !== '0)   begin n_fail++; $display("FAIL reset_dout got=%h exp=0", dout); end
        n_cmp++; if (txBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", txBusy); end
        n_cmp++; if (txDone !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", txDone); end
        reset = 1'b0;
        step();
    endtask

    // One full transfer: optional load, start, optional stall window and
    // optional sample/startTx poke mid-transfer; result lands in last_seq.
    task automatic run_transfer(input logic [31:0] w, input bit do_sample, input bit start_en,
                                input int stall_at, input int stall_len, input bit poke,
                                input string tag);
        logic [W-1:0] last;
        bit           en;
        bit           finished;
        int           done_cyc;
        last_seq.delete();
        if (do_sample) begin
            din = w; sample = 1'b1;
            step();
            sample = 1'b0;
        end
        txEn = start_en; startTx = 1'b1;
        step();
        startTx = 1'b0;
        n_cmp++; if (txBusy !== 1'b1) begin n_fail++; $display("FAIL %s start_busy got=%b exp=1", tag, txBusy); end
        last_seq.push_back(dout);
        last = dout;
        finished = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= NCH + stall_len + 5 && !finished; c++) begin
            en   = !(c >= stall_at && c < stall_at + stall_len);
            txEn = en;
            if (poke && c == 3) begin din = '0; sample = 1'b1; startTx = 1'b1; end
            step();
            sample = 1'b0; startTx = 1'b0;
            if (!en) begin
                n_cmp++; if (dout !== last || txBusy !== 1'b1 || txDone !== 1'b0) begin
                    n_fail++; $display("FAIL %s stall_hold c=%0d got=%h/%b/%b exp=%h/1/0", tag, c, dout, txBusy, txDone, last);
                end
            end else if (txDone === 1'b1) begin
                finished = 1'b1;
                done_cyc = c;
                n_cmp++; if (txBusy !== 1'b0 || dout !== '0) begin
                    n_fail++; $display("FAIL %s done_outputs got=%b/%h exp=0/0", tag, txBusy, dout);
                end
            end else if (txBusy === 1'b1) begin
                last_seq.push_back(dout);
                last = dout;
            end else begin
                n_cmp++; n_fail++;
                $display("FAIL %s busy_dropped c=%0d got=0 exp=1", tag, c);
            end
        end
        n_cmp++; if (!finished) begin n_fail++; $display("FAIL %s done_timeout got=none exp=pulse", tag); end
        n_cmp++; if (done_cyc != NCH + stall_len) begin
            n_fail++; $display("FAIL %s done_latency got=%0d exp=%0d", tag, done_cyc, NCH + stall_len);
        end
        n_cmp++; if (last_seq.size() != NCH) begin
            n_fail++; $display("FAIL %s chunk_count got=%0d exp=%0d", tag, last_seq.size(), NCH);
        end
        for (int k = 0; k < NCH && k < last_seq.size(); k++) begin
            n_cmp++; if (last_seq[k] !== ref_chunk(w, k)) begin
                n_fail++; $display("FAIL %s chunk%0d got=%h exp=%h", tag, k, last_seq[k], ref_chunk(w, k));
            end
        end
        txEn = 1'b1;
        step();
        n_cmp++; if (txDone !== 1'b0 || txBusy !== 1'b0 || dout !== '0) begin
            n_fail++; $display("FAIL %s after_done got=%b/%b/%h exp=0/0/0", tag, txDone, txBusy, dout);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_tab[NCH];
`ifdef SERIAL_TX_MSB_FIRST_EN
        exp_tab = '{5'h03, 5'h18, 5'h10, 5'h1E, 5'h04, 5'h07, 5'h11};
`else
        exp_tab = '{5'h11, 5'h07, 5'h04, 5'h1E, 5'h10, 5'h18, 5'h03};
`endif
        run_transfer(32'hF10F10F1, 1'b1, 1'b1, 0, 0, 1'b0, "basic");
        for (int k = 0; k < NCH && k < last_seq.size(); k++) begin
            n_cmp++; if (last_seq[k] !== exp_tab[k]) begin
                n_fail++; $display("FAIL basic_vector chunk%0d got=%h exp=%h", k, last_seq[k], exp_tab[k]);
            end
        end
    endtask

    task automatic test_stall();
        run_transfer(32'hF10F10F1, 1'b1, 1'b1, 2, 3, 1'b0, "stall");
    endtask

    task automatic test_ignore_busy();
        run_transfer(32'hF10F10F1, 1'b1, 1'b1, 0, 0, 1'b1, "ignore");
        // holding register must still be F10F10F1 after the poke
        run_transfer(32'hF10F10F1, 1'b0, 1'b1, 0, 0, 1'b0, "ignore_hold");
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int i = 0; i < 6; i++) begin
            w = $urandom;
            run_transfer(w, 1'b1, 1'(i % 2), $urandom_range(1, NCH - 1), $urandom_range(0, 3),
                         1'(i == 3), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_abort();
        din = 32'hF10F10F1; sample = 1'b1;
        step();
        sample = 1'b0; txEn = 1'b1; startTx = 1'b1;
        step();
        startTx = 1'b0;
        step();
        step();
        n_cmp++; if (dout !== ref_chunk(32'hF10F10F1, 2)) begin
            n_fail++; $display("FAIL abort_pre chunk2 got=%h exp=%h", dout, ref_chunk(32'hF10F10F1, 2));
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (dout !== '0 || txBusy !== 1'b0 || txDone !== 1'b0) begin
            n_fail++; $display("FAIL abort_async got=%h/%b/%b exp=0/0/0", dout, txBusy, txDone);
        end
        step();
        step();
        n_cmp++; if (txDone !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b exp=0", txDone); end
        reset = 1'b0;
        step();
        run_transfer(32'h0, 1'b0, 1'b1, 0, 0, 1'b0, "abort_zero");
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int          m;
        int          period;
        period = NCH + 2;
        w = $urandom;
        din = w; sample = 1'b1;
        step();
        sample = 1'b0; txEn = 1'b1; startTx = 1'b1;
        step();
        for (int c = 0; c < 2 * period; c++) begin
            m = c % period;
            if (m < NCH) begin
                n_cmp++; if (dout !== ref_chunk(w, m) || txBusy !== 1'b1 || txDone !== 1'b0) begin
                    n_fail++; $display("FAIL b2b c=%0d got=%h/%b/%b exp=%h/1/0", c, dout, txBusy, txDone, ref_chunk(w, m));
                end
            end else if (m == NCH) begin
                n_cmp++; if (dout !== '0 || txBusy !== 1'b0 || txDone !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_done c=%0d got=%h/%b/%b exp=0/0/1", c, dout, txBusy, txDone);
                end
            end else begin
                n_cmp++; if (dout !== '0 || txBusy !== 1'b0 || txDone !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_idle c=%0d got=%h/%b/%b exp=0/0/0", c, dout, txBusy, txDone);
                end
            end
            if (c == 2 * period - 1) startTx = 1'b0;
            step();
        end
        n_cmp++; if (txBusy !== 1'b0 || txDone !== 1'b0) begin
            n_fail++; $display("FAIL b2b_stop got=%b/%b exp=0/0", txBusy, txDone);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ignore_busy();
        test_random();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
